vx_writeback_arbiter: RTL and testbench

- Writeback stage directly upstream of the per-warp register files.
- Arbitrates between execute-unit results and memory-load responses with valid/ready handshakes.
- Registers the winning result and drives one shared write port to all warps' register files: warp-select one-hot, write flag, rd, data.
- Holds a committed write while a warp-spawn register copy is in progress, because a register file ignores normal writes during wspawn.

---
 rtl/vx_wb_pkg.sv | 31 +++
 rtl/vx_writeback_arbiter_if.sv | 48 ++++
 rtl/vx_rr_arb2.sv | 42 ++++
 rtl/vx_writeback_arbiter.sv | 119 +++++++++++
 tb/tb_vx_writeback_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vx_wb_pkg.sv
// Shared definitions for the writeback arbiter slice.
//   - Default warp count, register-index and data widths.
//   - Source encoding used by the round-robin arbiter and the top level.
//   - wb_req_t: one writeback request {warp_num, wb, rd, data}.
//   - wr_en(): the register-write qualifier (x0 is never written).
package vx_wb_pkg;

  localparam int NUM_WARPS_DEF = 8;
  localparam int REG_W         = 5;
  localparam int DATA_W        = 32;
  // warp_num is carried at a fixed maximum width so the struct can live in
  // the package; the top level zero-extends into it.
  localparam int WARP_MAX_W    = 8;

  typedef enum logic {
    SRC_EXE = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  typedef struct packed {
    logic [WARP_MAX_W-1:0] warp_num;
    logic                  wb;
    logic [REG_W-1:0]      rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  function automatic logic wr_en(input logic wb, input logic [REG_W-1:0] rd);
    return wb && (rd != '0);
  endfunction

endpackage

// File: rtl/vx_writeback_arbiter_if.sv
// Handshake/bus bundle of the writeback arbiter.
//   exe_*  : execute-unit result channel (valid/ready)
//   mem_*  : memory load-response channel (valid/ready)
//   out_*  : shared register-file write port
// Modports:
//   slave  : the arbiter's view (consumes exe/mem, drives readies and out_*)
//   master : the environment's view (drives exe/mem, observes the rest)
interface vx_writeback_arbiter_if #(
  parameter int NUM_WARPS = 8,
  parameter int WARP_W    = $clog2(NUM_WARPS)
);

  logic              exe_valid;
  logic              exe_ready;
  logic [WARP_W-1:0] exe_warp_num;
  logic              exe_wb;
  logic [4:0]        exe_rd;
  logic [31:0]       exe_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [WARP_W-1:0] mem_warp_num;
  logic              mem_wb;
  logic [4:0]        mem_rd;
  logic [31:0]       mem_data;

  logic                 out_valid;
  logic [NUM_WARPS-1:0] out_wb_warp;
  logic [WARP_W-1:0]    out_warp_num;
  logic                 out_write_register;
  logic [4:0]           out_rd;
  logic [31:0]          out_data;

  modport slave (
    input  exe_valid, exe_warp_num, exe_wb, exe_rd, exe_data,
    input  mem_valid, mem_warp_num, mem_wb, mem_rd, mem_data,
    output exe_ready, mem_ready,
    output out_valid, out_wb_warp, out_warp_num, out_write_register, out_rd, out_data
  );

  modport master (
    output exe_valid, exe_warp_num, exe_wb, exe_rd, exe_data,
    output mem_valid, mem_warp_num, mem_wb, mem_rd, mem_data,
    input  exe_ready, mem_ready,
    input  out_valid, out_wb_warp, out_warp_num, out_write_register, out_rd, out_data
  );

endinterface

// File: rtl/vx_rr_arb2.sv
// Two-requester round-robin arbiter (EXE vs MEM).
//   clk, reset   : clock, asynchronous active-low reset
//   req_exe_i    : execute source requesting
//   req_mem_i    : memory source requesting
//   advance_i    : the current grant was consumed this cycle
//   gnt_valid_o  : some source is granted
//   gnt_src_o    : granted source
// last_grant resets to MEM so that EXE wins the first conflict.
module vx_rr_arb2
  import vx_wb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_exe_i,
  input  logic req_mem_i,
  input  logic advance_i,
  output logic gnt_valid_o,
  output src_e gnt_src_o
);

  src_e last_grant_q;
  src_e last_grant_d;

  always_comb begin
    gnt_valid_o = req_exe_i || req_mem_i;
    gnt_src_o   = SRC_EXE;
    if (req_exe_i && req_mem_i) begin
      // On a conflict the source that did not win last time goes first.
      gnt_src_o = (last_grant_q == SRC_EXE) ? SRC_MEM : SRC_EXE;
    end else if (req_mem_i) begin
      gnt_src_o = SRC_MEM;
    end
    // Priority only rotates when a grant is actually consumed.
    last_grant_d = advance_i ? gnt_src_o : last_grant_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_grant_q <= SRC_MEM;
    else        last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/vx_writeback_arbiter.sv
// Writeback arbiter: picks between execute results and load responses,
// registers the winner and drives one shared write port to all warps'
// register files.
//   clk, reset      : clock, asynchronous active-low reset
//   wspawn_busy     : a register file is copying for wspawn; hold the output
//   bus (slave)     : exe/mem request channels and the out_* write port
//   stat_commits    : committed beats that actually wrote a register
//   stat_conflicts  : cycles where both sources were valid
module vx_writeback_arbiter
  import vx_wb_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_DEF,
  parameter int WARP_W    = $clog2(NUM_WARPS),
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wspawn_busy,
  vx_writeback_arbiter_if.slave bus,
  output logic [CNT_W-1:0]     stat_commits,
  output logic [CNT_W-1:0]     stat_conflicts
);

  logic    load_en, commit, xfer, gnt_valid;
  src_e    gnt_src;
  wb_req_t exe_req, mem_req, sel_req;

  logic                 out_valid_q, out_valid_d;
  logic [NUM_WARPS-1:0] out_wb_warp_q, out_wb_warp_d;
  logic [WARP_W-1:0]    out_warp_q, out_warp_d;
  logic                 out_wr_q, out_wr_d;
  logic [REG_W-1:0]     out_rd_q, out_rd_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [CNT_W-1:0]     commits_q, commits_d;
  logic [CNT_W-1:0]     conflicts_q, conflicts_d;

  assign exe_req = '{warp_num: WARP_MAX_W'(bus.exe_warp_num), wb: bus.exe_wb,
                     rd: bus.exe_rd, data: bus.exe_data};
  assign mem_req = '{warp_num: WARP_MAX_W'(bus.mem_warp_num), wb: bus.mem_wb,
                     rd: bus.mem_rd, data: bus.mem_data};
  assign sel_req = (gnt_src == SRC_EXE) ? exe_req : mem_req;

  // The register file samples the output in any cycle it is valid and not
  // blocked by wspawn, so the register is free to reload in that same cycle.
  assign commit  = out_valid_q && !wspawn_busy;
  assign load_en = !out_valid_q || !wspawn_busy;

  vx_rr_arb2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_exe_i   (bus.exe_valid),
    .req_mem_i   (bus.mem_valid),
    .advance_i   (xfer),
    .gnt_valid_o (gnt_valid),
    .gnt_src_o   (gnt_src)
  );

  // Readies are gated by reset so nothing is accepted while it is asserted.
  assign bus.exe_ready = reset && load_en && gnt_valid && (gnt_src == SRC_EXE);
  assign bus.mem_ready = reset && load_en && gnt_valid && (gnt_src == SRC_MEM);
  assign xfer = (bus.exe_valid && bus.exe_ready) || (bus.mem_valid && bus.mem_ready);

  always_comb begin
    out_valid_d   = out_valid_q;
    out_wb_warp_d = out_wb_warp_q;
    out_warp_d    = out_warp_q;
    out_wr_d      = out_wr_q;
    out_rd_d      = out_rd_q;
    out_data_d    = out_data_q;
    if (xfer) begin
      out_valid_d   = 1'b1;
      out_wb_warp_d = NUM_WARPS'(1) << sel_req.warp_num;
      out_warp_d    = sel_req.warp_num[WARP_W-1:0];
      out_wr_d      = wr_en(sel_req.wb, sel_req.rd);
      out_rd_d      = sel_req.rd;
      out_data_d    = sel_req.data;
    end else if (commit) begin
      // Drained with nothing behind it: deselect every warp; rd/data keep
      // their stale values since nobody looks at them.
      out_valid_d   = 1'b0;
      out_wb_warp_d = '0;
      out_wr_d      = 1'b0;
    end
    commits_d   = commits_q + CNT_W'(commit && out_wr_q);
    conflicts_d = conflicts_q + CNT_W'(bus.exe_valid && bus.mem_valid);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q   <= 1'b0;
      out_wb_warp_q <= '0;
      out_warp_q    <= '0;
      out_wr_q      <= 1'b0;
      out_rd_q      <= '0;
      out_data_q    <= '0;
      commits_q     <= '0;
      conflicts_q   <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_wb_warp_q <= out_wb_warp_d;
      out_warp_q    <= out_warp_d;
      out_wr_q      <= out_wr_d;
      out_rd_q      <= out_rd_d;
      out_data_q    <= out_data_d;
      commits_q     <= commits_d;
      conflicts_q   <= conflicts_d;
    end
  end

  assign bus.out_valid          = out_valid_q;
  assign bus.out_wb_warp        = out_wb_warp_q;
  assign bus.out_warp_num       = out_warp_q;
  assign bus.out_write_register = out_wr_q;
  assign bus.out_rd             = out_rd_q;
  assign bus.out_data           = out_data_q;
  assign stat_commits           = commits_q;
  assign stat_conflicts         = conflicts_q;

endmodule

// File: tb/tb_vx_writeback_arbiter.sv
// Self-checking bench for vx_writeback_arbiter: a behavioural model of the
// output register, grant rotation and counters is checked on every falling
// edge, and a directed sequence pins literal values along the way.
module tb_vx_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wspawn_busy = 1'b0;
  logic [31:0] stat_commits, stat_conflicts;

  int n_cmp = 0;
  int n_err = 0;

  vx_writeback_arbiter_if #(.NUM_WARPS(8)) bus ();

  vx_writeback_arbiter #(.NUM_WARPS(8), .WARP_W(3), .CNT_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .wspawn_busy    (wspawn_busy),
    .bus            (bus),
    .stat_commits   (stat_commits),
    .stat_conflicts (stat_conflicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid, m_wr, m_last_mem;
  logic [2:0]  m_warp;
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_commits, m_conflicts;

  // 0 = EXE, 1 = MEM, 2 = nobody
  function automatic int pick(input logic e, input logic m, input logic last_mem);
    if (e && m) return last_mem ? 0 : 1;
    if (e) return 0;
    if (m) return 1;
    return 2;
  endfunction

  function automatic logic m_room();
    return !m_valid || !wspawn_busy;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 0; m_wr <= 0; m_warp <= 0; m_rd <= 0; m_data <= 0;
      m_commits <= 0; m_conflicts <= 0; m_last_mem <= 1;
    end else begin
      if (m_valid && !wspawn_busy && m_wr) m_commits <= m_commits + 1;
      if (bus.exe_valid && bus.mem_valid) m_conflicts <= m_conflicts + 1;
      if (m_room() && pick(bus.exe_valid, bus.mem_valid, m_last_mem) == 0) begin
        m_valid <= 1; m_warp <= bus.exe_warp_num; m_rd <= bus.exe_rd;
        m_wr <= bus.exe_wb && (bus.exe_rd != 0); m_data <= bus.exe_data; m_last_mem <= 0;
      end else if (m_room() && pick(bus.exe_valid, bus.mem_valid, m_last_mem) == 1) begin
        m_valid <= 1; m_warp <= bus.mem_warp_num; m_rd <= bus.mem_rd;
        m_wr <= bus.mem_wb && (bus.mem_rd != 0); m_data <= bus.mem_data; m_last_mem <= 1;
      end else if (m_room()) begin
        m_valid <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_exe_ready", bus.exe_ready, 0);
      chk("rst_mem_ready", bus.mem_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
    end else begin
      chk("m_exe_ready", bus.exe_ready,
          m_room() && pick(bus.exe_valid, bus.mem_valid, m_last_mem) == 0);
      chk("m_mem_ready", bus.mem_ready,
          m_room() && pick(bus.exe_valid, bus.mem_valid, m_last_mem) == 1);
      chk("m_out_valid", bus.out_valid, m_valid);
      chk("m_out_wb_warp", bus.out_wb_warp, m_valid ? (8'd1 << m_warp) : 8'd0);
      if (m_valid) begin
        chk("m_out_warp_num", bus.out_warp_num, m_warp);
        chk("m_out_write_register", bus.out_write_register, m_wr);
        chk("m_out_rd", bus.out_rd, m_rd);
        chk("m_out_data", bus.out_data, m_data);
      end
      chk("m_stat_commits", stat_commits, m_commits);
      chk("m_stat_conflicts", stat_conflicts, m_conflicts);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_exe(input bit v, input int w, input bit wbf, input int rd, input logic [31:0] d);
    bus.exe_valid = v; bus.exe_warp_num = 3'(w); bus.exe_wb = wbf;
    bus.exe_rd = 5'(rd); bus.exe_data = d;
  endtask

  task automatic set_mem(input bit v, input int w, input bit wbf, input int rd, input logic [31:0] d);
    bus.mem_valid = v; bus.mem_warp_num = 3'(w); bus.mem_wb = wbf;
    bus.mem_rd = 5'(rd); bus.mem_data = d;
  endtask

  logic [31:0] conf_exp [4] = '{32'hE000_0000, 32'hA000_0000, 32'hE000_0001, 32'hA000_0001};

  initial begin
    int ei, mi;
    set_exe(0, 0, 0, 0, 0);
    set_mem(0, 0, 0, 0, 0);

    // Reset: nothing accepted even with a request present.
    tick();
    set_exe(1, 1, 1, 1, 32'h1111_1111);
    #1;
    chk("reset_exe_ready", bus.exe_ready, 0);
    chk("reset_out_wb_warp", bus.out_wb_warp, 0);
    chk("reset_out_data", bus.out_data, 0);
    tick();
    set_exe(0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("post_reset_commits", stat_commits, 0);
    chk("post_reset_conflicts", stat_conflicts, 0);
    tick();

    // Single EXE beat.
    set_exe(1, 3, 1, 5, 32'hDEAD_BEEF);
    #1;
    chk("single_exe_ready", bus.exe_ready, 1);
    tick();
    set_exe(0, 0, 0, 0, 0);
    chk("single_out_valid", bus.out_valid, 1);
    chk("single_out_wb_warp", bus.out_wb_warp, 8'h08);
    chk("single_out_wr", bus.out_write_register, 1);
    chk("single_out_rd", bus.out_rd, 5);
    chk("single_out_data", bus.out_data, 32'hDEAD_BEEF);
    tick();
    chk("single_drained", bus.out_valid, 0);
    chk("single_commits", stat_commits, 1);

    // x0 write from MEM: consumes a beat but does not write.
    set_mem(1, 6, 1, 0, 32'h0000_1234);
    #1;
    chk("x0_mem_ready", bus.mem_ready, 1);
    tick();
    set_mem(0, 0, 0, 0, 0);
    chk("x0_out_valid", bus.out_valid, 1);
    chk("x0_out_wr", bus.out_write_register, 0);
    chk("x0_out_wb_warp", bus.out_wb_warp, 8'h40);
    chk("x0_out_data", bus.out_data, 32'h0000_1234);
    tick();
    chk("x0_commits", stat_commits, 1);

    // Conflict: both valid, EXE first, strict alternation.
    ei = 0; mi = 0;
    for (int k = 0; k < 4; k++) begin
      set_exe(1, 1, 1, 1, 32'hE000_0000 + ei);
      set_mem(1, 2, 1, 2, 32'hA000_0000 + mi);
      #1;
      chk("conf_exe_ready", bus.exe_ready, (k % 2) == 0);
      chk("conf_mem_ready", bus.mem_ready, (k % 2) == 1);
      tick();
      chk("conf_out_data", bus.out_data, conf_exp[k]);
      if (k % 2 == 0) ei++; else mi++;
    end
    set_mem(0, 0, 0, 0, 0);
    set_exe(1, 5, 1, 7, 32'h5555_AAAA);
    chk("conf_count", stat_conflicts, 4);
    tick();

    // wspawn stall: held beat stays, nothing accepted for 3 cycles.
    wspawn_busy = 1'b1;
    set_exe(1, 5, 1, 8, 32'h6666_0000);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_exe_ready", bus.exe_ready, 0);
      chk("stall_mem_ready", bus.mem_ready, 0);
      tick();
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_out_data", bus.out_data, 32'h5555_AAAA);
      chk("stall_commits", stat_commits, 5);
    end
    wspawn_busy = 1'b0;
    #1;
    chk("resume_exe_ready", bus.exe_ready, 1);
    tick();
    chk("resume_out_data", bus.out_data, 32'h6666_0000);
    chk("resume_commits", stat_commits, 6);
    set_exe(0, 0, 0, 0, 0);
    tick();
    chk("resume_drained", bus.out_valid, 0);
    chk("resume_commits2", stat_commits, 7);

    // Back-to-back streaming.
    for (int i = 0; i < 8; i++) begin
      set_exe(1, i, 1, i + 1, 32'h100 + i);
      #1;
      chk("stream_exe_ready", bus.exe_ready, 1);
      tick();
      chk("stream_out_valid", bus.out_valid, 1);
      chk("stream_out_data", bus.out_data, 32'h100 + i);
      chk("stream_out_wb_warp", bus.out_wb_warp, 8'd1 << i);
    end
    set_exe(0, 0, 0, 0, 0);
    tick();
    chk("stream_commits", stat_commits, 15);

    // Async reset between edges while a beat is held.
    set_exe(1, 4, 1, 9, 32'hCAFE_0000);
    tick();
    chk("areset_pre_valid", bus.out_valid, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("areset_out_valid", bus.out_valid, 0);
    chk("areset_out_wb_warp", bus.out_wb_warp, 0);
    chk("areset_commits", stat_commits, 0);
    chk("areset_conflicts", stat_conflicts, 0);
    chk("areset_exe_ready", bus.exe_ready, 0);
    tick();
    set_exe(0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    set_exe(1, 2, 1, 3, 32'hE000_00AA);
    set_mem(1, 3, 1, 4, 32'hA000_00AA);
    #1;
    chk("rr_after_reset_exe", bus.exe_ready, 1);
    chk("rr_after_reset_mem", bus.mem_ready, 0);
    tick();
    chk("rr_after_reset_data", bus.out_data, 32'hE000_00AA);
    set_exe(0, 0, 0, 0, 0);
    set_mem(0, 0, 0, 0, 0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
